// File: rtl/mor1kx_wb_latch_marocchino.sv
// mor1kx_wb_latch_marocchino: write-back latch of the MAROCCHINO pipeline.
// Registers execute results and owns the architectural SR[F/CY/OV] and FPCSR state.
`ifndef OR1K_FPCSR_WIDTH
`define OR1K_FPCSR_WIDTH 12
`endif

module mor1kx_wb_latch_marocchino #(
    parameter OPTION_OPERAND_WIDTH = 32,
    parameter OPTION_RF_ADDR_WIDTH = 5,
    parameter FEATURE_OVERFLOW     = "NONE",
    parameter FEATURE_CARRY_FLAG   = "ENABLED",
    parameter FEATURE_FPU          = "NONE"
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_wb_i,
    input  logic                            pipeline_flush_i,
    input  logic                            exec_valid_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] alu_nl_result_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd_adr_i,
    input  logic                            exec_rf_wb_i,
    input  logic                            exec_flag_set_i,
    input  logic                            exec_flag_clear_i,
    input  logic                            exec_carry_set_i,
    input  logic                            exec_carry_clear_i,
    input  logic                            exec_overflow_set_i,
    input  logic                            exec_overflow_clear_i,
    input  logic [`OR1K_FPCSR_WIDTH-1:0]    exec_fpcsr_i,
    input  logic                            exec_fpcsr_set_i,
    input  logic                            sr_ove_i,
    input  logic                            spr_sr_we_i,
    input  logic                            spr_sr_flag_i,
    input  logic                            spr_sr_carry_i,
    input  logic                            spr_sr_ov_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic                            wb_rf_we_o,
    output logic                            wb_valid_o,
    output logic                            wb_except_range_o,
    output logic                            flag_o,
    output logic                            carry_o,
    output logic                            overflow_o,
    output logic [`OR1K_FPCSR_WIDTH-1:0]    fpcsr_o,
    output logic                            wb_fpcsr_set_o
);
    localparam logic HAS_OV  = (FEATURE_OVERFLOW != "NONE");
    localparam logic HAS_CY  = (FEATURE_CARRY_FLAG != "NONE");
    localparam logic HAS_FPU = (FEATURE_FPU != "NONE");

    logic                            commit, range;
    logic [OPTION_OPERAND_WIDTH-1:0] result_d, result_q;
    logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_d, rfd_adr_q;
    logic                            rf_we_d, rf_we_q, valid_d, valid_q, except_d, except_q;
    logic                            flag_d, flag_q, carry_d, carry_q, ov_d, ov_q;
    logic [`OR1K_FPCSR_WIDTH-1:0]    fpcsr_d, fpcsr_q;
    logic                            fpcsr_set_d, fpcsr_set_q;

    always_comb begin
        commit      = padv_wb_i & exec_valid_i & ~pipeline_flush_i;
        range       = HAS_OV & exec_overflow_set_i & sr_ove_i;
        result_d    = commit ? alu_nl_result_i : result_q;
        rfd_adr_d   = commit ? exec_rfd_adr_i : rfd_adr_q;
        valid_d     = commit;
        rf_we_d     = commit & exec_rf_wb_i & ~range;
        except_d    = commit & range;
        // mtspr SR overrides any same-cycle flag/carry/overflow update from execute
        flag_d      = spr_sr_we_i ? spr_sr_flag_i :
                      (commit & exec_flag_set_i) | (flag_q & ~(commit & exec_flag_clear_i));
        carry_d     = HAS_CY & (spr_sr_we_i ? spr_sr_carry_i :
                      (commit & exec_carry_set_i) | (carry_q & ~(commit & exec_carry_clear_i)));
        ov_d        = HAS_OV & (spr_sr_we_i ? spr_sr_ov_i :
                      (commit & exec_overflow_set_i) | (ov_q & ~(commit & exec_overflow_clear_i)));
        fpcsr_set_d = HAS_FPU & commit & exec_fpcsr_set_i;
        fpcsr_d     = fpcsr_set_d ? exec_fpcsr_i : fpcsr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            rfd_adr_q   <= '0;
            rf_we_q     <= 1'b0;
            valid_q     <= 1'b0;
            except_q    <= 1'b0;
            flag_q      <= 1'b0;
            carry_q     <= 1'b0;
            ov_q        <= 1'b0;
            fpcsr_q     <= '0;
            fpcsr_set_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            rfd_adr_q   <= rfd_adr_d;
            rf_we_q     <= rf_we_d;
            valid_q     <= valid_d;
            except_q    <= except_d;
            flag_q      <= flag_d;
            carry_q     <= carry_d;
            ov_q        <= ov_d;
            fpcsr_q     <= fpcsr_d;
            fpcsr_set_q <= fpcsr_set_d;
        end
    end

    assign wb_result_o       = result_q;
    assign wb_rfd_adr_o      = rfd_adr_q;
    assign wb_rf_we_o        = rf_we_q;
    assign wb_valid_o        = valid_q;
    assign wb_except_range_o = except_q;
    assign flag_o            = flag_q;
    assign carry_o           = carry_q;
    assign overflow_o        = ov_q;
    assign fpcsr_o           = fpcsr_q;
    assign wb_fpcsr_set_o    = fpcsr_set_q;
endmodule

// File: tb/tb_mor1kx_wb_latch_marocchino.sv
// tb_mor1kx_wb_latch_marocchino: directed vector table, async reset sequence and
// randomized run against a reference model of the write-back latch.
module tb_mor1kx_wb_latch_marocchino;
    localparam int FW = 12;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic padv, flush, valid, rfwb, fs, fc, cs, cc, os, oc, fps, ove, sprwe, sf, sc, so;
    logic [31:0] res;
    logic [4:0] adr;
    logic [FW-1:0] fp;
    logic [31:0] wb_result;
    logic [4:0] wb_adr;
    logic wb_we, wb_valid, wb_exc, flag, carry, ovf, wb_fps;
    logic [FW-1:0] fpcsr;

    mor1kx_wb_latch_marocchino #(
        .FEATURE_OVERFLOW("ENABLED"), .FEATURE_CARRY_FLAG("ENABLED"), .FEATURE_FPU("ENABLED")
    ) dut (
        .clk(clk), .rst(rst), .padv_wb_i(padv), .pipeline_flush_i(flush), .exec_valid_i(valid),
        .alu_nl_result_i(res), .exec_rfd_adr_i(adr), .exec_rf_wb_i(rfwb),
        .exec_flag_set_i(fs), .exec_flag_clear_i(fc), .exec_carry_set_i(cs), .exec_carry_clear_i(cc),
        .exec_overflow_set_i(os), .exec_overflow_clear_i(oc), .exec_fpcsr_i(fp), .exec_fpcsr_set_i(fps),
        .sr_ove_i(ove), .spr_sr_we_i(sprwe), .spr_sr_flag_i(sf), .spr_sr_carry_i(sc), .spr_sr_ov_i(so),
        .wb_result_o(wb_result), .wb_rfd_adr_o(wb_adr), .wb_rf_we_o(wb_we), .wb_valid_o(wb_valid),
        .wb_except_range_o(wb_exc), .flag_o(flag), .carry_o(carry), .overflow_o(ovf),
        .fpcsr_o(fpcsr), .wb_fpcsr_set_o(wb_fps)
    );

    typedef struct packed {
        logic padv, valid, flush, rfwb;
        logic [31:0] res;
        logic [4:0] adr;
        logic [5:0] upd;   // {fs,fc,cs,cc,os,oc}
        logic ove;
        logic [3:0] spr;   // {we,f,c,o}
        logic fps;
        logic [FW-1:0] fp;
    } vin_t;

    typedef struct {
        vin_t i;
        logic [31:0] e_res;
        logic [4:0] e_adr;
        logic [3:0] e_ctl; // {we,valid,exc,fpset}
        logic [2:0] e_sr;  // {flag,carry,ov}
        logic [FW-1:0] e_fp;
    } vec_t;

    int tests = 0, fails = 0;
    logic [31:0] m_res;
    logic [4:0] m_adr;
    logic [3:0] m_ctl;
    logic [2:0] m_sr;
    logic [FW-1:0] m_fp;

    function automatic vin_t mkin(logic p, logic v, logic f, logic w, logic [31:0] r, logic [4:0] a,
                                  logic [5:0] u, logic o, logic [3:0] s, logic ps, logic [FW-1:0] x);
        mkin = '{p, v, f, w, r, a, u, o, s, ps, x};
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic check_all(input logic [31:0] r, input logic [4:0] a, input logic [3:0] c,
                             input logic [2:0] s, input logic [FW-1:0] x, input string tag);
        check({tag, ".result"}, wb_result, r);
        check({tag, ".adr"}, 32'(wb_adr), 32'(a));
        check({tag, ".ctl"}, 32'({wb_we, wb_valid, wb_exc, wb_fps}), 32'(c));
        check({tag, ".sr"}, 32'({flag, carry, ovf}), 32'(s));
        check({tag, ".fpcsr"}, 32'(fpcsr), 32'(x));
    endtask

    task automatic model_reset();
        m_res = 0; m_adr = 0; m_ctl = 0; m_sr = 0; m_fp = 0;
    endtask

    // Drive inputs and advance the reference model to the state expected after the next edge
    task automatic apply(input vin_t v);
        logic commit, range;
        {padv, valid, flush, rfwb, res, adr} = {v.padv, v.valid, v.flush, v.rfwb, v.res, v.adr};
        {fs, fc, cs, cc, os, oc} = v.upd;
        {ove, fps, fp} = {v.ove, v.fps, v.fp};
        {sprwe, sf, sc, so} = v.spr;
        commit = v.padv && v.valid && !v.flush;
        range = v.upd[1] && v.ove;
        m_ctl = 4'b0;
        if (commit) begin
            m_res = v.res;
            m_adr = v.adr;
            m_ctl = {v.rfwb && !range, 1'b1, range, v.fps};
            if (v.fps) m_fp = v.fp;
            for (int b = 0; b < 3; b++) begin
                if (v.upd[5-2*b]) m_sr[2-b] = 1'b1;
                else if (v.upd[4-2*b]) m_sr[2-b] = 1'b0;
            end
        end
        if (v.spr[3]) m_sr = v.spr[2:0];
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vt[13];

    initial begin
        vt[0]  = '{mkin(1,1,0,1,32'h1234,5'd3,6'b000000,0,4'b0000,0,12'h0), 32'h1234, 5'd3, 4'b1100, 3'b000, 12'h0};
        vt[1]  = '{mkin(0,1,0,1,32'h9999,5'd9,6'b000000,0,4'b0000,0,12'h0), 32'h1234, 5'd3, 4'b0000, 3'b000, 12'h0};
        vt[2]  = '{mkin(1,1,0,0,32'h10,5'd4,6'b100000,0,4'b0000,0,12'h0), 32'h10, 5'd4, 4'b0100, 3'b100, 12'h0};
        vt[3]  = '{mkin(1,1,0,1,32'h11,5'd5,6'b010000,0,4'b0000,0,12'h0), 32'h11, 5'd5, 4'b1100, 3'b000, 12'h0};
        vt[4]  = '{mkin(1,1,0,1,32'h12,5'd6,6'b110000,0,4'b0000,0,12'h0), 32'h12, 5'd6, 4'b1100, 3'b100, 12'h0};
        vt[5]  = '{mkin(1,1,0,1,32'h20,5'd7,6'b000010,1,4'b0000,0,12'h0), 32'h20, 5'd7, 4'b0110, 3'b101, 12'h0};
        vt[6]  = '{mkin(1,1,0,1,32'h21,5'd8,6'b000010,0,4'b0000,0,12'h0), 32'h21, 5'd8, 4'b1100, 3'b101, 12'h0};
        vt[7]  = '{mkin(1,1,1,1,32'h30,5'd9,6'b001000,0,4'b0000,0,12'h0), 32'h21, 5'd8, 4'b0000, 3'b101, 12'h0};
        vt[8]  = '{mkin(1,1,0,1,32'h31,5'd10,6'b100000,0,4'b1010,0,12'h0), 32'h31, 5'd10, 4'b1100, 3'b010, 12'h0};
        vt[9]  = '{mkin(1,1,0,0,32'h40,5'd11,6'b000000,0,4'b0000,1,12'h0A1), 32'h40, 5'd11, 4'b0101, 3'b010, 12'h0A1};
        vt[10] = '{mkin(1,0,0,1,32'h50,5'd12,6'b100000,0,4'b0000,1,12'h123), 32'h40, 5'd11, 4'b0000, 3'b010, 12'h0A1};
        vt[11] = '{mkin(1,1,0,1,32'h60,5'd13,6'b000101,0,4'b0000,0,12'h0), 32'h60, 5'd13, 4'b1100, 3'b000, 12'h0A1};
        vt[12] = '{mkin(1,1,0,1,32'h61,5'd14,6'b000000,0,4'b0000,0,12'h0), 32'h61, 5'd14, 4'b1100, 3'b000, 12'h0A1};

        model_reset();
        apply('0);
        repeat (2) @(negedge clk);
        rst = 0;
        check_all(0, 0, 0, 0, 0, "reset");

        for (int k = 0; k < 13; k++) begin
            apply(vt[k].i);
            step();
            check_all(vt[k].e_res, vt[k].e_adr, vt[k].e_ctl, vt[k].e_sr, vt[k].e_fp, $sformatf("vec%0d", k));
        end

        // Asynchronous reset arriving mid-cycle must clear committed state before the next edge
        apply(mkin(1,1,0,1,32'hABCD,5'd17,6'b101010,0,4'b0000,1,12'h3C));
        @(posedge clk);
        #2 rst = 1;
        #1 check_all(0, 0, 0, 0, 0, "async_rst");
        model_reset();
        apply('0);
        @(negedge clk);
        rst = 0;
        step();
        check_all(m_res, m_adr, m_ctl, m_sr, m_fp, "post_rst");

        for (int n = 0; n < 400; n++) begin
            vin_t v;
            v.padv  = ($urandom_range(3) != 0);
            v.valid = ($urandom_range(3) != 0);
            v.flush = ($urandom_range(9) == 0);
            v.rfwb  = 1'($urandom);
            v.res   = $urandom;
            v.adr   = 5'($urandom);
            v.upd   = 6'($urandom);
            v.ove   = 1'($urandom);
            v.spr   = (!v.flush && $urandom_range(7) == 0) ? {1'b1, 3'($urandom)} : 4'b0;
            v.fps   = 1'($urandom);
            v.fp    = FW'($urandom);
            apply(v);
            step();
            check_all(m_res, m_adr, m_ctl, m_sr, m_fp, $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
